// File: rtl/csa64_sub_seq.sv
// Sequential 64-bit subtractor: op1 - op2 computed one carry-select slice per cycle,
// with registered borrow, signed-overflow and zero flags and a one-cycle done pulse.
module csa64_sub_seq #(
    parameter int SLICE_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    input  logic        start,
    output logic [63:0] diff,
    output logic        brout,
    output logic        ovf,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    localparam int NUM_SLICES = 64 / SLICE_W;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int LOG_W      = $clog2(SLICE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [63:0]              a_q;
    logic [63:0]              b_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     cin_q;
    logic [63:0]              diff_q;
    logic                     brout_q;
    logic                     ovf_q;
    logic                     zero_q;

    logic [IDX_W+LOG_W-1:0]   slice_lo;
    logic [SLICE_W-1:0]       a_sl;
    logic [SLICE_W-1:0]       b_sl;
    logic [SLICE_W:0]         sum0;
    logic [SLICE_W:0]         sum1;
    logic [SLICE_W:0]         sum_sel;
    logic [63:0]              diff_d;
    logic                     cout;
    logic                     last_slice;

    // Slice offset is idx * SLICE_W; SLICE_W is a power of two, so it is a plain concatenation.
    assign slice_lo = {idx_q, {LOG_W{1'b0}}};

    // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
    always_comb begin
        a_sl       = a_q[slice_lo +: SLICE_W];
        b_sl       = b_q[slice_lo +: SLICE_W];
        sum0       = {1'b0, a_sl} + {1'b0, ~b_sl};
        sum1       = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE_W{1'b0}}, 1'b1};
        sum_sel    = cin_q ? sum1 : sum0;
        cout       = sum_sel[SLICE_W];
        diff_d     = diff_q;
        diff_d[slice_lo +: SLICE_W] = sum_sel[SLICE_W-1:0];
        last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: captured operands are left out of reset; they are always loaded before use.
            state_q <= IDLE;
            idx_q   <= '0;
            cin_q   <= 1'b1;
            diff_q  <= '0;
            brout_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= op1;
                        b_q     <= op2;
                        idx_q   <= '0;
                        cin_q   <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q <= diff_d;
                    cin_q  <= cout;
                    idx_q  <= idx_q + IDX_W'(1);
                    if (last_slice) begin
                        // Subtraction carry-out is the inverted borrow.
                        brout_q <= ~cout;
                        ovf_q   <= (a_q[63] != b_q[63]) && (diff_d[63] != a_q[63]);
                        zero_q  <= (diff_d == 64'd0);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff  = diff_q;
    assign brout = brout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_csa64_sub_seq.sv
// Directed self-checking bench for csa64_sub_seq at the default 16-bit slice width.
module tb_csa64_sub_seq;

    logic        clock;
    logic        reset;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        start;
    logic [63:0] diff;
    logic        brout;
    logic        ovf;
    logic        zero;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] d;
        logic        br;
        logic        ov;
        logic        z;
    } vec_t;

    csa64_sub_seq dut (
        .clock (clock),
        .reset (reset),
        .op1   (op1),
        .op2   (op2),
        .start (start),
        .diff  (diff),
        .brout (brout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one operation from a negedge; returns the negedge index at which done was seen
    // (-1 on timeout) and how many earlier sampled cycles showed busy without done.
    task automatic launch(input logic [63:0] a, input logic [63:0] b,
                          output int cyc, output int busy_cnt);
        op1      = a;
        op2      = b;
        start    = 1'b1;
        cyc      = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        int cyc;
        int bc;
        reset = 1'b1;
        start = 1'b1;
        op1   = 64'h1111_2222_3333_4444;
        op2   = 64'h0000_0000_0000_0001;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({diff, brout, ovf, zero, busy, done} !== {64'd0, 5'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got diff=%h br=%b ov=%b z=%b busy=%b done=%b, want all zero",
                     diff, brout, ovf, zero, busy, done);
        end
        // start already high: the first edge with reset low must capture.
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_start_accept: busy=%b, want 1", busy);
        end
        start = 1'b0;
        cyc = -1;
        for (int i = 2; i <= 30; i++) begin
            @(negedge clock);
            if (done) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (cyc != 5 || diff !== 64'h1111_2222_3333_4443) begin
            n_fail++;
            $display("FAIL first_start_result: cyc=%0d diff=%h, want cyc=5 diff=1111222233334443", cyc, diff);
        end
        @(negedge clock);
        bc = 0;
    endtask

    task automatic test_sub;
        vec_t vecs[6];
        int   cyc;
        int   bc;
        vecs[0] = '{64'h1234_ffff_dfff_eeee, 64'hdddd_dddd_dddd_dddd, 64'h3457_2222_0222_1111, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_ffff_ffff, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h7fff_ffff_ffff_ffff, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{64'hdead_beef_cafe_f00d, 64'hdead_beef_cafe_f00d, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{64'h7fff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
        foreach (vecs[k]) begin
            launch(vecs[k].a, vecs[k].b, cyc, bc);
            n_checks++;
            if (cyc != 5 || bc != 4) begin
                n_fail++;
                $display("FAIL latency_%0d: done at cycle %0d with %0d busy cycles, want 5 and 4", k, cyc, bc);
            end
            n_checks++;
            if (diff !== vecs[k].d) begin
                n_fail++;
                $display("FAIL diff_%0d: got %h want %h", k, diff, vecs[k].d);
            end
            n_checks++;
            if ({brout, ovf, zero} !== {vecs[k].br, vecs[k].ov, vecs[k].z}) begin
                n_fail++;
                $display("FAIL flags_%0d: br/ov/z got %b%b%b want %b%b%b", k, brout, ovf, zero,
                         vecs[k].br, vecs[k].ov, vecs[k].z);
            end
            // Changing idle operands must not disturb the held result.
            op1 = 64'h5555_5555_5555_5555;
            op2 = 64'h0123_4567_89ab_cdef;
            @(negedge clock);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse_%0d: done=%b busy=%b after DONE, want 0 0", k, done, busy);
            end
            repeat (2) @(negedge clock);
            n_checks++;
            if ({diff, brout, ovf, zero} !== {vecs[k].d, vecs[k].br, vecs[k].ov, vecs[k].z}) begin
                n_fail++;
                $display("FAIL hold_%0d: diff=%h flags=%b%b%b, want %h %b%b%b", k, diff, brout, ovf, zero,
                         vecs[k].d, vecs[k].br, vecs[k].ov, vecs[k].z);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int n_done;
        op1   = 64'h1234_ffff_dfff_eeee;
        op2   = 64'hdddd_dddd_dddd_dddd;
        start = 1'b1;
        @(negedge clock);
        op1 = 64'h0000_0001_0000_0000;
        op2 = 64'h0000_0000_0000_0001;
        cyc = -1;
        for (int i = 2; i <= 30; i++) begin
            @(negedge clock);
            if (done) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (cyc != 5 || diff !== 64'h3457_2222_0222_1111) begin
            n_fail++;
            $display("FAIL b2b_first: cyc=%0d diff=%h, want 5 and 3457222202221111", cyc, diff);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: done=%b busy=%b, want 0 0", done, busy);
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_recapture: busy=%b done=%b, want 1 0", busy, done);
        end
        cyc = -1;
        for (int i = 2; i <= 30; i++) begin
            @(negedge clock);
            if (done) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (cyc != 5 || diff !== 64'h0000_0000_ffff_ffff) begin
            n_fail++;
            $display("FAIL b2b_second: cyc=%0d diff=%h, want 5 and 00000000ffffffff", cyc, diff);
        end
        n_done = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL b2b_no_extra: %0d extra done cycles, want 0", n_done);
        end
    endtask

    task automatic test_mid_reset;
        int cyc;
        int bc;
        int n_done;
        op1   = 64'h0000_0000_0000_0000;
        op2   = 64'h0000_0000_0000_0001;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({diff, brout, ovf, zero, busy, done} !== {64'd0, 5'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_clear: diff=%h br=%b ov=%b z=%b busy=%b done=%b, want all zero",
                     diff, brout, ovf, zero, busy, done);
        end
        reset  = 1'b0;
        n_done = 0;
        repeat (8) begin
            @(negedge clock);
            if (done || busy) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL mid_reset_abort: %0d busy/done cycles after abort, want 0", n_done);
        end
        launch(64'hffff_ffff_ffff_ffff, 64'h0000_0000_0000_0000, cyc, bc);
        n_checks++;
        if (cyc != 5 || diff !== 64'hffff_ffff_ffff_ffff || {brout, ovf, zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_recover: cyc=%0d diff=%h flags=%b%b%b, want 5 ffffffffffffffff 000",
                     cyc, diff, brout, ovf, zero);
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op1   = '0;
        op2   = '0;
        test_reset();
        test_sub();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
